// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-mode loader: FSM state encoding and
// default bus/MAR widths used by the loader, the bus and the MAR.
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    SETADDR = 3'd2,
    WRITE   = 3'd3,
    VERIFY  = 3'd4,
    NEXT    = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_addrctr.sv
// Load address counter: clears to zero, increments, and never wraps past
// DEPTH-1; last flags the final address.
module prog_loader_addrctr #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              zero,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  assign last = (cnt == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program-mode loader: takes over bus/MAR/RAM writes while pmode is high and
// stores a valid/ready byte stream at addresses 0..DEPTH-1.
// Readback verify is compiled in with PROG_LOADER_READBACK_EN.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready is registered and never depends on in_valid.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pmode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              marwa,
  output logic              ramwa,
  output logic              ramoa,
  output logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  state_t            state;
  logic              pmode_q;
  logic [DATA_W-1:0] byte_q;
  logic              ramoa_q;
  logic              err_q;
  logic              last;
  logic              ctr_zero;
  logic              ctr_inc;

  // Counter controls follow the same pmode gating as the FSM so that a
  // dropped pmode freezes addr exactly where the load stopped.
  assign ctr_zero = (state == IDLE) && pmode && !pmode_q;
  assign ctr_inc  = (state == NEXT) && pmode && !last;

  prog_loader_addrctr #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_addrctr (
    .clk (clk),
    .clr (clr),
    .zero(ctr_zero),
    .inc (ctr_inc),
    .cnt (addr),
    .last(last)
  );

  assign ramoa     = ramoa_q;
  assign err       = err_q;
  assign state_dbg = state;

`ifndef PROG_LOADER_READBACK_EN
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
`endif

  // Outputs are registered with the values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      pmode_q  <= 1'b0;
      byte_q   <= '0;
      in_ready <= 1'b0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      marwa    <= 1'b0;
      ramwa    <= 1'b0;
      ramoa_q  <= 1'b0;
      done     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pmode_q  <= pmode;
      in_ready <= 1'b0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      marwa    <= 1'b0;
      ramwa    <= 1'b0;
      ramoa_q  <= 1'b0;
      if (!pmode) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!pmode_q) begin
              state    <= WAIT;
              in_ready <= 1'b1;
              done     <= 1'b0;
              err_q    <= 1'b0;
            end
          end
          WAIT: begin
            if (in_valid && in_ready) begin
              byte_q  <= in_data;
              state   <= SETADDR;
              bus_oe  <= 1'b1;
              bus_out <= DATA_W'(addr);
              marwa   <= 1'b1;
            end else begin
              in_ready <= 1'b1;
            end
          end
          SETADDR: begin
            state   <= WRITE;
            bus_oe  <= 1'b1;
            bus_out <= byte_q;
            ramwa   <= 1'b1;
          end
          WRITE: begin
`ifdef PROG_LOADER_READBACK_EN
            state   <= VERIFY;
            ramoa_q <= 1'b1;
`else
            state   <= NEXT;
`endif
          end
          VERIFY: begin
`ifdef PROG_LOADER_READBACK_EN
            if (bus_in != byte_q) begin
              err_q <= 1'b1;
            end
`endif
            state <= NEXT;
          end
          NEXT: begin
            if (last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state    <= WAIT;
              in_ready <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a RAM/MAR model on the bus side
// and a byte-stream model of what each load should leave in RAM.
module tb_prog_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef PROG_LOADER_READBACK_EN
  localparam bit EXP_RB = 1'b1;
`else
  localparam bit EXP_RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          pmode;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          marwa;
  logic          ramwa;
  logic          ramoa;
  logic [AW-1:0] addr;
  logic          done;
  logic          err;
  logic [2:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  // reference model of the load
  logic [DW-1:0] exp_q[$];
  int            exp_addr;
  bit            exp_err;
  bit            exp_done;

  // bus-side RAM/MAR model
  logic [DW-1:0] ram[DEPTH];
  logic [AW-1:0] mar = '0;
  bit            corrupt = 1'b0;
  bit            ramoa_seen = 1'b0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .pmode(pmode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .marwa(marwa), .ramwa(ramwa), .ramoa(ramoa), .addr(addr), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  always @(posedge clk) begin
    if (marwa) mar <= bus_out[AW-1:0];
    if (ramwa) ram[mar] <= bus_out;
  end

  assign bus_in = ramoa ? ((corrupt && mar == 4'd3) ? 8'hFF : ram[mar])
                        : (bus_oe ? bus_out : '0);

  always @(negedge clk) begin
    if (clr === 1'b1) begin
      checks++;
      if ({bus_oe && ramoa, $countones({marwa, ramwa, ramoa}) > 1} !== 2'b00) begin
        failures++;
        $display("FAIL exclusion t=%0t marwa=%b ramwa=%b ramoa=%b bus_oe=%b required at most one enable",
                 $time, marwa, ramwa, ramoa, bus_oe);
      end
      if (ramoa === 1'b1) ramoa_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    exp_q.delete();
    exp_addr = 0;
    exp_err  = 1'b0;
    exp_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  endtask

  // Called at a negedge; returns at the negedge of the NEXT cycle (or after the drop).
  task automatic send_byte(input logic [DW-1:0] b, input bit drop, output int waits);
    in_data  = b;
    in_valid = 1'b1;
    waits    = 0;
    while (in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({marwa, ramwa, bus_oe, in_ready, bus_out, addr} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 8'(exp_addr), 4'(exp_addr)}) begin
      failures++;
      $display("FAIL setaddr marwa=%b ramwa=%b oe=%b rdy=%b bus=%h addr=%h required 1 0 1 0 %h %h",
               marwa, ramwa, bus_oe, in_ready, bus_out, addr, 8'(exp_addr), 4'(exp_addr));
    end
    if (drop) begin
      pmode = 1'b0;
      @(negedge clk);
      checks++;
      if ({marwa, ramwa, ramoa, bus_oe, in_ready, done, addr} !== {6'b0, 4'(exp_addr)}) begin
        failures++;
        $display("FAIL pmode_drop en=%b%b%b oe=%b rdy=%b done=%b addr=%h required all 0 addr=%h",
                 marwa, ramwa, ramoa, bus_oe, in_ready, done, addr, 4'(exp_addr));
      end
      return;
    end
    @(negedge clk);
    checks++;
    if ({ramwa, marwa, ramoa, bus_oe, bus_out} !== {4'b1001, b}) begin
      failures++;
      $display("FAIL write ramwa=%b marwa=%b ramoa=%b oe=%b bus=%h required 1 0 0 1 %h",
               ramwa, marwa, ramoa, bus_oe, bus_out, b);
    end
`ifdef PROG_LOADER_READBACK_EN
    @(negedge clk);
    checks++;
    if ({ramoa, bus_oe, marwa, ramwa} !== 4'b1000) begin
      failures++;
      $display("FAIL verify ramoa=%b oe=%b marwa=%b ramwa=%b required 1 0 0 0",
               ramoa, bus_oe, marwa, ramwa);
    end
    if (corrupt && exp_addr == 3) exp_err = 1'b1;
`endif
    @(negedge clk);
    checks++;
    if ({marwa, ramwa, ramoa, bus_oe, in_ready, err} !== {5'b0, exp_err}) begin
      failures++;
      $display("FAIL next en=%b%b%b oe=%b rdy=%b err=%b required 00000 err=%b",
               marwa, ramwa, ramoa, bus_oe, in_ready, err, exp_err);
    end
    exp_q.push_back(b);
    if (exp_addr < DEPTH - 1) exp_addr++;
    else exp_done = 1'b1;
  endtask

  // pmode low for one edge, then a rising edge; returns in WAIT.
  task automatic start_load();
    @(negedge clk);
    pmode    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    pmode = 1'b1;
    @(negedge clk);
    clear_model();
    checks++;
    if ({in_ready, done, err, addr} !== {3'b100, 4'h0}) begin
      failures++;
      $display("FAIL start rdy=%b done=%b err=%b addr=%h required 1 0 0 0",
               in_ready, done, err, addr);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; pmode = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, bus_out, bus_oe, marwa, ramwa, ramoa, addr, done, err} !== '0) begin
      failures++;
      $display("FAIL reset rdy=%b bus=%h oe=%b en=%b%b%b addr=%h done=%b err=%b required all 0",
               in_ready, bus_out, bus_oe, marwa, ramwa, ramoa, addr, done, err);
    end
    clr = 1'b1;
    @(negedge clk);
    clear_model();
    checks++;
    if ({in_ready, addr, done} !== {1'b1, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release rdy=%b addr=%h done=%b required 1 0 0", in_ready, addr, done);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(16 + i), 1'b0, w);
      if (i > 0) begin
        checks++;
        if (w !== 1) begin
          failures++;
          $display("FAIL b2b_ready_latency byte=%0d waited=%0d required 1", i, w);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({done, in_ready, addr} !== {exp_done, 1'b0, 4'(DEPTH - 1)}) begin
      failures++;
      $display("FAIL b2b_done done=%b rdy=%b addr=%h required %b 0 %h",
               done, in_ready, addr, exp_done, 4'(DEPTH - 1));
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({in_ready, marwa, ramwa} !== 3'b000) begin
        failures++;
        $display("FAIL after_done rdy=%b marwa=%b ramwa=%b required 0 0 0", in_ready, marwa, ramwa);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram[i] !== 8'(16 + i)) begin
        failures++;
        $display("FAIL b2b_ram addr=%0d got=%h required %h", i, ram[i], 8'(16 + i));
      end
    end
  endtask

  task automatic test_gaps();
    int w;
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(16 + i), 1'b0, w);
      in_valid = 1'b0;
      if (i < DEPTH - 1) begin
        repeat (3) begin
          @(negedge clk);
          checks++;
          if ({in_ready, marwa, ramwa, ramoa, bus_oe} !== 5'b10000) begin
            failures++;
            $display("FAIL gap_idle rdy=%b en=%b%b%b oe=%b required 1 000 0",
                     in_ready, marwa, ramwa, ramoa, bus_oe);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({done, addr} !== {exp_done, 4'(DEPTH - 1)}) begin
      failures++;
      $display("FAIL gaps_done done=%b addr=%h required %b %h", done, addr, exp_done, 4'(DEPTH - 1));
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram[i] !== 8'(16 + i)) begin
        failures++;
        $display("FAIL gaps_ram addr=%0d got=%h required %h", i, ram[i], 8'(16 + i));
      end
    end
  endtask

  task automatic test_pmode_drop();
    int w;
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, w);
    send_byte(8'($urandom_range(0, 255)), 1'b1, w);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready, marwa, done, addr} !== {3'b000, 4'd5}) begin
        failures++;
        $display("FAIL pmode_low rdy=%b marwa=%b done=%b addr=%h required 0 0 0 5",
                 in_ready, marwa, done, addr);
      end
    end
    in_valid = 1'b0;
    pmode = 1'b1;
    @(negedge clk);
    clear_model();
    checks++;
    if ({in_ready, done, addr} !== {2'b10, 4'h0}) begin
      failures++;
      $display("FAIL pmode_restart rdy=%b done=%b addr=%h required 1 0 0", in_ready, done, addr);
    end
  endtask

  task automatic test_readback();
    int w;
    corrupt = 1'b1;
    ramoa_seen = 1'b0;
    start_load();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(16 + i), 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, err, ramoa_seen} !== {1'b1, EXP_RB, EXP_RB}) begin
      failures++;
      $display("FAIL readback done=%b err=%b ramoa_seen=%b required 1 %b %b",
               done, err, ramoa_seen, EXP_RB, EXP_RB);
    end
    corrupt = 1'b0;
  endtask

  task automatic test_random();
    int w;
    int gap;
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0, w);
      in_valid = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if ({done, err, addr} !== {exp_done, 1'b0, 4'(DEPTH - 1)}) begin
      failures++;
      $display("FAIL random_done done=%b err=%b addr=%h required %b 0 %h",
               done, err, addr, exp_done, 4'(DEPTH - 1));
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_ram addr=%0d got=%h required %h", i, ram[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clr_mid();
    int w;
    start_load();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, w);
    in_valid = 1'b1;
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, bus_oe, marwa, ramwa, ramoa, done, err, addr, bus_out} !== '0) begin
      failures++;
      $display("FAIL clr_mid rdy=%b oe=%b en=%b%b%b done=%b err=%b addr=%h bus=%h required all 0",
               in_ready, bus_oe, marwa, ramwa, ramoa, done, err, addr, bus_out);
    end
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, addr} !== {1'b1, 4'h0}) begin
      failures++;
      $display("FAIL clr_release rdy=%b addr=%h required 1 0", in_ready, addr);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_pmode_drop();
    test_readback();
    test_random();
    test_clr_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
